abc_reg_access: RTL

Bus-slave front-end that sits directly upstream of the ABC register bank (r1, r2, r_counter). It accepts single read/write requests over a valid/ready handshake, decodes the word address, drives one-cycle write strobes into the bank or samples its readback value, and returns a response over a second valid/ready handshake. It also issues a count pulse toward r_counter for every successful access that is not a counter write.

---
 rtl/abc_reg_access.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/abc_reg_access.sv
// Bus-slave front-end for the ABC register bank (r1, r2, r_counter).
// One request at a time: IDLE accepts, EXEC strobes/samples the bank, RESP holds the response.
module abc_reg_access #(
    parameter int                 ADDR_W   = 8,
    parameter int                 DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  R1_ADDR  = ADDR_W'('h00),
    parameter logic [ADDR_W-1:0]  R2_ADDR  = ADDR_W'('h04),
    parameter logic [ADDR_W-1:0]  CNT_ADDR = ADDR_W'('h08)
) (
    input  logic              clk,
    input  logic              r,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,

    output logic              reg_r1_we,
    output logic              reg_r2_we,
    output logic              reg_cnt_we,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_r1_q,
    input  logic [DATA_W-1:0] reg_r2_q,
    input  logic [DATA_W-1:0] reg_cnt_q,

    output logic              cnt_inc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    logic                r_rstDone;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;

    logic                w_accept;
    logic                w_inExec;
    logic                w_aligned;
    logic                w_hitR1;
    logic                w_hitR2;
    logic                w_hitCnt;
    logic                w_hit;
    logic [DATA_W-1:0]   w_rdataNext;

    // r_rstDone keeps req_ready low while reset is held and until the first edge after release.
    assign req_ready = (r_state == IDLE) && r_rstDone;
    assign w_accept  = req_valid && req_ready;
    assign w_inExec  = (r_state == EXEC);

    assign w_aligned = (r_addr[1:0] == 2'b00);
    assign w_hitR1   = w_aligned && (r_addr == R1_ADDR);
    assign w_hitR2   = w_aligned && (r_addr == R2_ADDR);
    assign w_hitCnt  = w_aligned && (r_addr == CNT_ADDR);
    assign w_hit     = w_hitR1 || w_hitR2 || w_hitCnt;

    // Strobes are decoded from the registered state so an async reset drops them at once.
    assign reg_r1_we  = w_inExec && r_write && w_hitR1;
    assign reg_r2_we  = w_inExec && r_write && w_hitR2;
    assign reg_cnt_we = w_inExec && r_write && w_hitCnt;
    assign cnt_inc    = w_inExec && w_hit && !(r_write && w_hitCnt);
    assign reg_wdata  = r_wdata;

    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    always_comb begin
        w_rdataNext = '0;
        if (!r_write) begin
            if (w_hitR1) begin
                w_rdataNext = reg_r1_q;
            end else if (w_hitR2) begin
                w_rdataNext = reg_r2_q;
            end else if (w_hitCnt) begin
                w_rdataNext = reg_cnt_q;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = EXEC;
                end
            end
            EXEC: begin
                w_nextState = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            r_state   <= IDLE;
            r_rstDone <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_rstDone <= 1'b1;
        end
    end

    // The response is captured at the end of EXEC, so a counter read sees the pre-increment value.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (w_inExec) begin
                r_rdata <= w_rdataNext;
                r_err   <= !w_hit;
            end
        end
    end

endmodule
